// File: rtl/conversor_pkg.sv
// Shared constants and state type for the sequential binary-to-BCD converter.
package conversor_pkg;

  localparam int LARGURA_ENTRADA = 20;
  localparam int NUM_DIGITOS     = 6;

  function automatic logic [63:0] maximo_decimal(input int digitos);
    logic [63:0] acc;
    acc = 64'd1;
    for (int i = 0; i < digitos; i++) acc = acc * 64'd10;
    return acc - 64'd1;
  endfunction

  localparam logic [63:0] VALOR_MAXIMO = maximo_decimal(NUM_DIGITOS);
  localparam logic [4*NUM_DIGITOS-1:0] BCD_SATURADO = {NUM_DIGITOS{4'h9}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIM   = 2'd2
  } estado_t;

endpackage

// File: rtl/ajuste_digito_bcd.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module ajuste_digito_bcd (
  input  logic [3:0] digito_i,
  output logic [3:0] digito_o
);

  assign digito_o = (digito_i >= 4'd5) ? digito_i + 4'd3 : digito_i;

endmodule

// File: rtl/conversor_binario_bcd.sv
// Iterative binary-to-BCD converter (shift-and-add-3) with start/busy/done
// handshake; the published BCD word only changes on the final load edge.
module conversor_binario_bcd
  import conversor_pkg::*;
#(
  parameter int LARGURA_ENTRADA = conversor_pkg::LARGURA_ENTRADA,
  parameter int NUM_DIGITOS     = conversor_pkg::NUM_DIGITOS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [LARGURA_ENTRADA-1:0] binario,
  output logic [4*NUM_DIGITOS-1:0]   BCD,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow
);

  localparam int LARGURA_BCD  = 4 * NUM_DIGITOS;
  localparam int LARGURA_CONT = $clog2(LARGURA_ENTRADA + 1);
  localparam logic [63:0] LIMITE = maximo_decimal(NUM_DIGITOS);
  localparam logic [LARGURA_BCD-1:0] SATURADO = {NUM_DIGITOS{4'h9}};

  estado_t                    estado_q;
  logic [LARGURA_BCD-1:0]     acc_q, acc_ajustado, acc_d;
  logic [LARGURA_ENTRADA-1:0] bin_q, bin_d;
  logic [LARGURA_CONT-1:0]    cont_q, cont_d;
  logic                       excedeu_q;
  logic [LARGURA_BCD-1:0]     bcd_q;
  logic                       busy_q, done_q, overflow_q;

  for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_ajuste
    ajuste_digito_bcd u_ajuste (
      .digito_i (acc_q[4*g +: 4]),
      .digito_o (acc_ajustado[4*g +: 4])
    );
  end

  // The MSB of the corrected accumulator falls off the top; unreachable for in-range inputs.
  assign acc_d  = (acc_ajustado << 1) | LARGURA_BCD'(bin_q[LARGURA_ENTRADA-1]);
  assign bin_d  = bin_q << 1;
  assign cont_d = cont_q - LARGURA_CONT'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= IDLE;
      acc_q      <= '0;
      bin_q      <= '0;
      cont_q     <= '0;
      excedeu_q  <= 1'b0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (start) begin
            bin_q     <= binario;
            acc_q     <= '0;
            excedeu_q <= (64'(binario) > LIMITE);
            cont_q    <= LARGURA_CONT'(LARGURA_ENTRADA);
            busy_q    <= 1'b1;
            estado_q  <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q  <= acc_d;
          bin_q  <= bin_d;
          cont_q <= cont_d;
          if (cont_q == LARGURA_CONT'(1)) estado_q <= FIM;
        end
        FIM: begin
          bcd_q      <= excedeu_q ? SATURADO : acc_q;
          overflow_q <= excedeu_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          estado_q   <= IDLE;
        end
        default: begin
          estado_q <= IDLE;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign BCD      = bcd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Directed-vector bench for conversor_binario_bcd with hand-computed results.
module tb_conversor_binario_bcd;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [19:0] binario = '0;
  logic [23:0] BCD;
  logic        busy, done, overflow;

  int n_vec = 0;
  int n_err = 0;

  conversor_binario_bcd dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .binario  (binario),
    .BCD      (BCD),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_conv(input logic [19:0] val, input logic [23:0] exp_bcd,
                          input logic exp_ov, input string tag);
    int cyc;
    @(negedge clock);
    binario = val;
    start   = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      step();
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'd21);
    check({tag, "_bcd"}, 32'(BCD), 32'(exp_bcd));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ov));
    check({tag, "_idle"}, 32'(busy), 32'd0);
    step();
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin : stimulus
    int cyc;
    int extra;
    logic [23:0] seq_bcd [3];
    logic [19:0] seq_bin [3];

    repeat (3) @(negedge clock);
    check("rst_bcd", 32'(BCD), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;

    run_conv(20'd123456, 24'h123456, 1'b0, "c123456");
    run_conv(20'd0, 24'h000000, 1'b0, "c0");
    run_conv(20'd999999, 24'h999999, 1'b0, "c999999");
    run_conv(20'd1000000, 24'h999999, 1'b1, "c1000000");
    run_conv(20'd1048575, 24'h999999, 1'b1, "c1048575");
    run_conv(20'd42, 24'h000042, 1'b0, "c42");

    // start while busy must be ignored; binario changes must not leak in
    @(negedge clock);
    binario = 20'd500;
    start   = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    extra = 0;
    while (!done && cyc < 40) begin
      if (cyc == 4 || cyc == 20) begin
        binario = 20'd777;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check("busy_ign_lat", 32'(cyc), 32'd21);
    check("busy_ign_bcd", 32'(BCD), 32'h000500);
    repeat (30) begin
      step();
      if (done) extra++;
    end
    check("busy_ign_nodone", 32'(extra), 32'd0);
    check("busy_ign_idle", 32'(busy), 32'd0);
    check("busy_ign_hold", 32'(BCD), 32'h000500);

    // reset in the middle of a conversion
    @(negedge clock);
    binario = 20'd654321;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    #1;
    check("midrst_bcd", 32'(BCD), 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    extra = 0;
    repeat (30) begin
      step();
      if (done) extra++;
    end
    check("midrst_nodone", 32'(extra), 32'd0);
    run_conv(20'd31, 24'h000031, 1'b0, "c31");

    // start held high: back-to-back conversions every 22 cycles
    seq_bin[0] = 20'd9;     seq_bcd[0] = 24'h000009;
    seq_bin[1] = 20'd10;    seq_bcd[1] = 24'h000010;
    seq_bin[2] = 20'd99999; seq_bcd[2] = 24'h099999;
    @(negedge clock);
    binario = seq_bin[0];
    start   = 1'b1;
    step();
    cyc = 0;
    for (int k = 0; k < 3; k++) begin
      do begin
        step();
        cyc++;
      end while (!done && cyc < 40);
      check($sformatf("hold_gap%0d", k), 32'(cyc), (k == 0) ? 32'd21 : 32'd22);
      check($sformatf("hold_bcd%0d", k), 32'(BCD), 32'(seq_bcd[k]));
      if (k < 2) binario = seq_bin[k+1];
      else start = 1'b0;
      cyc = 0;
    end
    step();
    check("hold_stop", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conversor_binario_bcd.md
Name: conversor_binario_bcd

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3).
- Produces the packed 6-digit BCD word consumed by the 7-segment display driver, so binary counters and scores can be shown on HEX0..HEX5.
- Uses a start/busy/done handshake.
- Holds the last result stable between conversions so the combinational display path never shows intermediate values.

Parameters:
- LARGURA_ENTRADA, 20, width of the binary input in bits; also the number of shift iterations.
- NUM_DIGITOS, 6, number of BCD digits produced; output width is 4*NUM_DIGITOS.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- binario  input  LARGURA_ENTRADA  unsigned value to convert; captured on the edge that accepts start.
- BCD  output  4*NUM_DIGITOS  packed result. BCD[3:0] is units, BCD[7:4] is tens, and so on up to BCD[23:20] for hundred-thousands.
- busy  output  1  high while a conversion is in progress (SHIFT and FIM states).
- done  output  1  one-cycle pulse when BCD and overflow have just been updated.
- overflow  output  1  high when the last captured input exceeded 10^NUM_DIGITOS-1 (999999).

Behaviour:
- Reset (async, active-high), effective immediately regardless of clock:
  - state returns to IDLE;
  - BCD=0x000000, busy=0, done=0, overflow=0;
  - internal shift registers and counter are cleared.
- FSM states: IDLE, SHIFT, FIM.
- IDLE:
  - busy=0.
  - On an edge with start=1: capture binario into the binary shift register and clear the BCD accumulator.
  - Register excedeu = (binario > 999999) and load the iteration counter with LARGURA_ENTRADA.
  - Go to SHIFT.
  - start=0 keeps the FSM in IDLE.
- SHIFT:
  - busy=1.
  - Each edge: every accumulator nibble >= 5 gets +3 (all nibbles evaluated in parallel from current values).
  - Then shift {accumulator, binary register} left by 1 and decrement the counter.
  - After the LARGURA_ENTRADA-th shift (counter reaches 0), go to FIM.
- FIM:
  - busy=1.
  - On the next edge, load BCD = excedeu ? 0x999999 (all digits 9) : accumulator, and overflow = excedeu.
  - Set done=1 for exactly the following cycle; return to IDLE.
- Latency: done is high during the cycle beginning 22 edges after the accepting edge. That is 1 capture edge, 20 shift edges, and 1 load edge; done is observed after edge 22.
- BCD and overflow change only on the load edge and hold until the next conversion completes or reset.
- Accumulator width is 4*NUM_DIGITOS. Shifts out of the MSB are discarded; this cannot occur for inputs <= 999999.
- For overflowing inputs, the conversion still runs full length; only the loaded value is saturated.
- Boundary cases:
  - start while busy=1 (SHIFT or FIM): ignored, no queueing.
  - start held high continuously: a new conversion is accepted every 22 cycles (first IDLE edge after done).
  - start asserted in the cycle where done=1 (FSM already in IDLE): accepted, which gives back-to-back conversions.
  - binario changing during a conversion: no effect; the value is latched at capture.
  - Reset mid-conversion: conversion aborted, no done pulse, BCD cleared to 0x000000.
  - Input 0: BCD=0x000000, overflow=0.

Decomposition:
- Shared package conversor_pkg:
  - LARGURA_ENTRADA=20, NUM_DIGITOS=6;
  - VALOR_MAXIMO=999999;
  - BCD_SATURADO=0x999999;
  - state enum {IDLE, SHIFT, FIM}.
- Sub-module ajuste_digito_bcd: 4-bit combinational "if >= 5 then +3".
  - Instantiated NUM_DIGITOS times in a generate loop.
  - Keeps the iteration datapath readable and reusable.

Test Plan:
- Reset, then start with binario=123456 -> after 22 edges done pulses once; BCD=0x123456, overflow=0, busy returns to 0.
- binario=0, then binario=999999 -> BCD=0x000000, then BCD=0x999999, overflow=0 for both.
- binario=1000000, then binario=1048575 -> BCD=0x999999 and overflow=1 for each. A following conversion of 42 -> BCD=0x000042, overflow=0.
- Start binario=500, then pulse start with binario=777 at cycles 5 and 21 of the conversion -> single result BCD=0x000500; no second done.
- Start binario=654321, assert reset at cycle 10 -> BCD=0x000000 immediately, busy=0, no done. Restart with 31 -> BCD=0x000031.
- start held high with binario stepping 9, 10, 99999 -> done pulses spaced 22 cycles apart; BCD sequence 0x000009, 0x000010, 0x099999.
